// File: rtl/seq_sub_pkg.sv
// seq_subtractor shared definitions: state encoding, counter sizing
// helper and the WIDTH/DIGIT divisibility guard macro.
`ifndef SEQ_SUB_PKG_SV
`define SEQ_SUB_PKG_SV

`define SEQ_SUB_CHECK(W, D) \
  if (((W) % (D)) != 0) begin : g_digit_chk \
    $error("seq_subtractor: WIDTH must be a multiple of DIGIT"); \
  end

package seq_sub_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } state_e;

  // never returns 0 so a single-step counter still has one bit
  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 32; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

endpackage

`endif

// File: rtl/sub_digit.sv
// Combinational W-bit subtractor built from a ripple of
// full-subtractor cells: d = a - b - bin, bo = final borrow.
module sub_digit #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         bin,
  output logic [W-1:0] d,
  output logic         bo
);

  logic [W:0] br;

  assign br[0] = bin;

  for (genvar i = 0; i < W; i++) begin : g_cell
    assign d[i]    = a[i] ^ b[i] ^ br[i];
    assign br[i+1] = (~a[i] & b[i])
                   | (~(a[i] ^ b[i]) & br[i]);
  end

  assign bo = br[W];

endmodule

// File: rtl/seq_subtractor.sv
// Sequential LSB-first subtractor, DIGIT bits per clock.
// SEQ_SUB_OVF_EN adds the signed-overflow output.
module seq_subtractor
  import seq_sub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
`ifdef SEQ_SUB_OVF_EN
  output logic             bo,
  output logic             ovf
`else
  output logic             bo
`endif
);

  localparam int STEPS = WIDTH / DIGIT;
  localparam int CW    = clog2(STEPS);

  `SEQ_SUB_CHECK(WIDTH, DIGIT)

  state_e           state;
  state_e           state_nx;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] d_sh;
  logic [WIDTH-1:0] d_nx;
  logic             brw;
  logic [DIGIT-1:0] dig;
  logic             dig_bo;
  logic             accept;
  logic             last;

  sub_digit #(.W(DIGIT)) u_digit (
    .a   (a_sh[DIGIT-1:0]),
    .b   (b_sh[DIGIT-1:0]),
    .bin (brw),
    .d   (dig),
    .bo  (dig_bo)
  );

  // result fills from the MSB end so it lands aligned after STEPS shifts
  if (STEPS == 1) begin : g_one
    assign d_nx = dig;
  end else begin : g_many
    assign d_nx = {dig, d_sh[WIDTH-1:DIGIT]};
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_ready && in_valid;
  assign last      = (state == RUN)
                  && (cnt == CW'(STEPS - 1));

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (in_valid)  state_nx = RUN;
      RUN:  if (last)      state_nx = DONE;
      DONE: if (out_ready) state_nx = IDLE;
      default:             state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      brw   <= 1'b0;
      a_sh  <= '0;
      b_sh  <= '0;
      d_sh  <= '0;
      d     <= '0;
      bo    <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        a_sh <= a;
        b_sh <= b;
        brw  <= bin;
        cnt  <= '0;
      end else if (state == RUN) begin
        a_sh <= a_sh >> DIGIT;
        b_sh <= b_sh >> DIGIT;
        brw  <= dig_bo;
        d_sh <= d_nx;
        cnt  <= cnt + 1'b1;
        if (last) begin
          d  <= d_nx;
          bo <= dig_bo;
        end
      end
    end
  end

`ifdef SEQ_SUB_OVF_EN
  logic a_msb;
  logic b_msb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      if (accept) begin
        a_msb <= a[WIDTH-1];
        b_msb <= b[WIDTH-1];
      end
      if (last)
        ovf <= (a_msb != b_msb)
            && (dig[DIGIT-1] != a_msb);
      else if (out_valid && out_ready)
        ovf <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_seq_subtractor.sv
// Randomized bench for seq_subtractor: DIGIT=4 and DIGIT=1
// instances run in lockstep against an arithmetic reference.
module tb_seq_subtractor;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        bin;
  logic        ir0, ov0, bo0;
  logic        ir1, ov1, bo1;
  logic [15:0] d0, d1;
`ifdef SEQ_SUB_OVF_EN
  logic        ovf0, ovf1;
`endif

  int n_chk;
  int n_err;

  seq_subtractor #(.WIDTH(16), .DIGIT(4)) u_d4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (ir0),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (ov0),
    .out_ready (out_ready),
    .d         (d0),
`ifdef SEQ_SUB_OVF_EN
    .bo        (bo0),
    .ovf       (ovf0)
`else
    .bo        (bo0)
`endif
  );

  seq_subtractor #(.WIDTH(16), .DIGIT(1)) u_d1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (ir1),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (ov1),
    .out_ready (out_ready),
    .d         (d1),
`ifdef SEQ_SUB_OVF_EN
    .bo        (bo1),
    .ovf       (ovf1)
`else
    .bo        (bo1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // {ovf, bo, d} from plain integer arithmetic
  function automatic logic [17:0] ref_sub(input logic [15:0] x,
                                          input logic [15:0] y,
                                          input logic c);
    int          diff;
    int          sd;
    logic [31:0] u;
    diff = int'(x) - int'(y) - int'(c);
    sd   = int'($signed(x)) - int'($signed(y)) - int'(c);
    u    = diff;
    return {(sd > 32767 || sd < -32768), (diff < 0), u[15:0]};
  endfunction

  task automatic run(input logic [15:0] ta,
                     input logic [15:0] tb,
                     input logic tbin,
                     input int hold);
    logic [17:0] e;
    logic [15:0] sd;
    logic        sb;
    int          l0;
    int          l1;
    e = ref_sub(ta, tb, tbin);
    @(negedge clk);
    chk("in_ready4", ir0, 1);
    chk("in_ready1", ir1, 1);
    a = ta;
    b = tb;
    bin = tbin;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = 16'($urandom);
    b = 16'($urandom);
    bin = 1'($urandom);
    l0 = -1;
    l1 = -1;
    for (int k = 0; k < 40 && (l0 < 0 || l1 < 0); k++) begin
      @(negedge clk);
      if (l0 < 0 && ov0) l0 = k;
      if (l1 < 0 && ov1) l1 = k;
    end
    chk("latency4", l0, 4);
    chk("latency1", l1, 16);
    sd = d0;
    sb = bo0;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_d", d0, sd);
      chk("hold_bo", bo0, sb);
      chk("hold_ov", ov0, 1);
      chk("hold_ir", ir0, 0);
      in_valid = 1'($urandom);
      a = 16'($urandom);
      b = 16'($urandom);
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("d4", d0, e[15:0]);
    chk("bo4", bo0, e[16]);
    chk("d1", d1, e[15:0]);
    chk("bo1", bo1, e[16]);
`ifdef SEQ_SUB_OVF_EN
    chk("ovf4", ovf0, e[17]);
    chk("ovf1", ovf1, e[17]);
`endif
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("idle_ir4", ir0, 1);
    chk("idle_ir1", ir1, 1);
    chk("idle_ov4", ov0, 0);
`ifdef SEQ_SUB_OVF_EN
    chk("idle_ovf4", ovf0, 0);
`endif
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    bin = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ov", ov0, 0);
    chk("rst_d", d0, 0);
    chk("rst_bo", bo0, 0);
`ifdef SEQ_SUB_OVF_EN
    chk("rst_ovf", ovf0, 0);
`endif
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ir", ir0, 1);

    run(16'h1234, 16'h0234, 1'b0, 0);
    run(16'h0000, 16'h0001, 1'b0, 0);
    run(16'h8000, 16'h0001, 1'b0, 0);
    run(16'hAAAA, 16'h5555, 1'b0, 0);
    run(16'h0000, 16'h8000, 1'b1, 0);
    run(16'hFFFF, 16'hFFFF, 1'b1, 0);
    run(16'($urandom), 16'($urandom), 1'($urandom), 10);

    // abort in the second RUN cycle
    @(negedge clk);
    a = 16'h4321;
    b = 16'h1111;
    bin = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_ov4", ov0, 0);
    chk("abort_ov1", ov1, 0);
    chk("abort_d4", d0, 0);
    chk("abort_d1", d1, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("abort_ir4", ir0, 1);
    chk("abort_ir1", ir1, 1);
    run(16'd5, 16'd7, 1'b1, 0);

    for (int i = 0; i < 25; i++)
      run(16'($urandom), 16'($urandom), 1'($urandom),
          int'($urandom_range(0, 2)));

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
